// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory request/response, branch redirect
// and the held-instruction handshake toward decode.
interface fetch_unit_if;
    logic        br_taken;
    logic [31:0] br_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready;

    modport master (
        input  br_taken, br_target, imem_gnt, imem_rvalid, imem_rdata, if_ready,
        output imem_req, imem_addr, if_valid, if_pc, if_instr
    );

    modport slave (
        output br_taken, br_target, imem_gnt, imem_rvalid, imem_rdata, if_ready,
        input  imem_req, imem_addr, if_valid, if_pc, if_instr
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, keeps one memory request outstanding, holds
// the returned instruction until decode takes it, and kills wrong-path fetches.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t      state_r, state_nxt_s;
    logic [31:0] pc_r, pc_seq_s, pc_nxt_s;
    logic [31:0] req_pc_r, req_pc_nxt_s;
    logic [31:0] if_pc_r, if_pc_nxt_s;
    logic [31:0] if_instr_r, if_instr_nxt_s;
    logic        kill_r, kill_nxt_s;
    logic        if_valid_r, if_valid_nxt_s;
    logic        imem_req_r;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    // Next-state, PC and holding-register update logic.
    always_comb begin
        state_nxt_s    = state_r;
        pc_seq_s       = pc_r;
        req_pc_nxt_s   = req_pc_r;
        kill_nxt_s     = kill_r;
        if_valid_nxt_s = if_valid_r;
        if_pc_nxt_s    = if_pc_r;
        if_instr_nxt_s = if_instr_r;
        case (state_r)
            IDLE: begin
                state_nxt_s = FETCH;
            end
            FETCH: begin
                if (bus.imem_gnt) begin
                    req_pc_nxt_s = pc_r;
                    pc_seq_s     = pc_r + 32'd4;
                    // A redirect coinciding with the grant makes this request wrong-path.
                    kill_nxt_s   = bus.br_taken;
                    state_nxt_s  = WAIT;
                end else begin
                    state_nxt_s = FETCH;
                end
            end
            WAIT: begin
                if (bus.imem_rvalid) begin
                    kill_nxt_s = 1'b0;
                    if (kill_r || bus.br_taken) begin
                        state_nxt_s = FETCH;
                    end else begin
                        if_valid_nxt_s = 1'b1;
                        if_pc_nxt_s    = req_pc_r;
                        if_instr_nxt_s = bus.imem_rdata;
                        state_nxt_s    = HOLD;
                    end
                end else if (bus.br_taken) begin
                    kill_nxt_s = 1'b1;
                end else begin
                    kill_nxt_s = kill_r;
                end
            end
            HOLD: begin
                if (bus.br_taken || bus.if_ready) begin
                    if_valid_nxt_s = 1'b0;
                    if_instr_nxt_s = NOP_INSTR;
                    state_nxt_s    = FETCH;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
        pc_nxt_s = bus.br_taken ? word_align(bus.br_target) : pc_seq_s;
    end

    // State and output registers; the request is registered so br_taken never reaches imem_* combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            pc_r       <= RESET_PC;
            req_pc_r   <= 32'h0000_0000;
            kill_r     <= 1'b0;
            if_valid_r <= 1'b0;
            if_pc_r    <= 32'h0000_0000;
            if_instr_r <= NOP_INSTR;
            imem_req_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            pc_r       <= pc_nxt_s;
            req_pc_r   <= req_pc_nxt_s;
            kill_r     <= kill_nxt_s;
            if_valid_r <= if_valid_nxt_s;
            if_pc_r    <= if_pc_nxt_s;
            if_instr_r <= if_instr_nxt_s;
            imem_req_r <= (state_nxt_s == FETCH);
        end
    end

    assign bus.imem_req  = imem_req_r;
    assign bus.imem_addr = pc_r;
    assign bus.if_valid  = if_valid_r;
    assign bus.if_pc     = if_pc_r;
    assign bus.if_instr  = if_instr_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// grant/latency/redirect traffic compared every cycle against a transaction model.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic rst_n;
    int   n_assert = 0;
    int   n_fail   = 0;

    fetch_unit_if ifc ();
    fetch_unit_if ifc2 ();

    fetch_unit u_dut (.clk(clk), .rst_n(rst_n), .bus(ifc));
    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(ifc2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Memory responder knobs
    int gnt_pct = 100;
    int kmin    = 1;
    int kmax    = 1;
    bit spur_en = 1'b0;

    // Instruction memory: random grant, response k>=1 cycles after grant,
    // optional spurious rvalid when nothing is pending.
    initial begin
        int          wcnt;
        logic [31:0] pend;
        wcnt = 0;
        pend = 32'h0;
        ifc.imem_gnt    = 1'b0;
        ifc.imem_rvalid = 1'b0;
        ifc.imem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            ifc.imem_rvalid = 1'b0;
            if (wcnt > 0) begin
                wcnt--;
                if (wcnt == 0) begin
                    ifc.imem_rvalid = 1'b1;
                    ifc.imem_rdata  = mem_word(pend);
                end
            end else if (spur_en && ($urandom_range(7) == 0)) begin
                ifc.imem_rvalid = 1'b1;
                ifc.imem_rdata  = $urandom;
            end
            ifc.imem_gnt = ($urandom_range(99) < gnt_pct);
            if (ifc.imem_req && ifc.imem_gnt) begin
                pend = ifc.imem_addr;
                wcnt = int'($urandom_range(kmax, kmin));
            end
        end
    end

    // Transaction-level reference model, advanced on each rising edge.
    bit          m_first = 1'b1;
    bit          m_out   = 1'b0;
    bit          m_killed = 1'b0;
    bit          m_held  = 1'b0;
    logic [31:0] m_next_pc = 32'h0;
    logic [31:0] m_out_pc = 32'h0;
    logic [31:0] m_held_pc = 32'h0;
    logic [31:0] m_held_instr = NOP;
    int          m_cyc = 0;
    logic [31:0] del_pc[$];
    logic [31:0] del_instr[$];
    int          del_cyc[$];

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_first   = 1'b1;
                m_out     = 1'b0;
                m_killed  = 1'b0;
                m_held    = 1'b0;
                m_next_pc = 32'h0;
            end else begin
                m_cyc++;
                if (m_first) begin
                    m_first = 1'b0;
                end else if (!m_out && !m_held) begin
                    if (ifc.imem_gnt) begin
                        m_out     = 1'b1;
                        m_out_pc  = m_next_pc;
                        m_killed  = ifc.br_taken;
                        m_next_pc = m_next_pc + 32'd4;
                    end
                end else if (m_out) begin
                    if (ifc.imem_rvalid) begin
                        m_out = 1'b0;
                        if (!m_killed && !ifc.br_taken) begin
                            m_held       = 1'b1;
                            m_held_pc    = m_out_pc;
                            m_held_instr = ifc.imem_rdata;
                        end
                        m_killed = 1'b0;
                    end else if (ifc.br_taken) begin
                        m_killed = 1'b1;
                    end
                end else begin
                    if (ifc.if_ready) begin
                        del_pc.push_back(m_held_pc);
                        del_instr.push_back(m_held_instr);
                        del_cyc.push_back(m_cyc);
                    end
                    if (ifc.if_ready || ifc.br_taken) m_held = 1'b0;
                end
                if (ifc.br_taken) m_next_pc = {ifc.br_target[31:2], 2'b00};
            end
        end
    end

    // Per-cycle comparison of DUT outputs against the model.
    initial begin
        bit exp_req;
        forever begin
            @(negedge clk);
            exp_req = !m_first && !m_out && !m_held;
            chk("imem_req", 32'(ifc.imem_req), 32'(exp_req));
            if (exp_req || !rst_n) chk("imem_addr", ifc.imem_addr, m_next_pc);
            chk("if_valid", 32'(ifc.if_valid), 32'(m_held));
            if (m_held) begin
                chk("if_pc", ifc.if_pc, m_held_pc);
                chk("if_instr", ifc.if_instr, m_held_instr);
            end else begin
                chk("if_instr_nop", ifc.if_instr, NOP);
            end
            if (!rst_n) chk("if_pc_reset", ifc.if_pc, 32'h0);
        end
    end

    // Second instance with RESET_PC at the top of memory: always granted, k=1.
    logic [31:0] addr2[2];
    int          n2 = 0;
    initial begin
        logic        g2;
        logic [31:0] a2;
        g2 = 1'b0;
        a2 = 32'h0;
        ifc2.br_taken    = 1'b0;
        ifc2.br_target   = 32'h0;
        ifc2.imem_gnt    = 1'b1;
        ifc2.imem_rvalid = 1'b0;
        ifc2.imem_rdata  = 32'h0;
        ifc2.if_ready    = 1'b1;
        forever begin
            @(negedge clk);
            ifc2.imem_rvalid = g2;
            ifc2.imem_rdata  = mem_word(a2);
            g2 = ifc2.imem_req;
            a2 = ifc2.imem_addr;
            if (ifc2.imem_req && (n2 < 2)) begin
                addr2[n2] = ifc2.imem_addr;
                n2++;
            end
        end
    end

    task automatic wait_req(input string nm);
        int c;
        c = 0;
        @(negedge clk);
        while (!ifc.imem_req && (c < 60)) begin
            @(negedge clk);
            c++;
        end
        chk(nm, 32'(ifc.imem_req), 32'd1);
    endtask

    task automatic wait_valid(input string nm);
        int c;
        c = 0;
        @(negedge clk);
        while (!ifc.if_valid && (c < 60)) begin
            @(negedge clk);
            c++;
        end
        chk(nm, 32'(ifc.if_valid), 32'd1);
    endtask

    task automatic wait_deliv(input int n);
        int c;
        c = 0;
        while ((del_pc.size() < n) && (c < 200)) begin
            @(negedge clk);
            c++;
        end
        chk("deliv_timeout", 32'(del_pc.size() >= n), 32'd1);
    endtask

    initial begin
        logic [31:0] cap_pc;
        logic [31:0] cap_instr;
        int          n0;
        rst_n         = 1'b0;
        ifc.br_taken  = 1'b0;
        ifc.br_target = 32'h0;
        ifc.if_ready  = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_req", 32'(ifc.imem_req), 32'd0);
        chk("rst_addr", ifc.imem_addr, 32'h0);
        chk("rst_valid", 32'(ifc.if_valid), 32'd0);
        chk("rst_pc", ifc.if_pc, 32'h0);
        chk("rst_instr", ifc.if_instr, NOP);
        rst_n = 1'b1;

        // Sequential fetch, gnt always, k=1
        wait_deliv(3);
        if (del_pc.size() >= 3) begin
            chk("seq_pc0", del_pc[0], 32'h0);
            chk("seq_pc1", del_pc[1], 32'h4);
            chk("seq_pc2", del_pc[2], 32'h8);
            chk("seq_instr1", del_instr[1], 32'h0004_FFFB);
            chk("seq_gap", 32'(del_cyc[2] - del_cyc[1]), 32'd3);
        end

        // Downstream stall for 5 cycles
        ifc.if_ready = 1'b0;
        wait_valid("stall_valid");
        cap_pc    = ifc.if_pc;
        cap_instr = ifc.if_instr;
        for (int i = 0; i < 5; i++) begin
            chk("stall_pc", ifc.if_pc, cap_pc);
            chk("stall_instr", ifc.if_instr, cap_instr);
            chk("stall_req", 32'(ifc.imem_req), 32'd0);
            @(negedge clk);
        end
        ifc.if_ready = 1'b1;
        wait_req("stall_next_req");
        chk("stall_next_addr", ifc.imem_addr, cap_pc + 32'd4);

        // Redirect while waiting (k=3), unaligned target
        kmin = 3;
        kmax = 3;
        wait_req("wait_br_req");
        @(negedge clk);
        n0 = del_pc.size();
        ifc.br_taken  = 1'b1;
        ifc.br_target = 32'h0000_1003;
        @(negedge clk);
        ifc.br_taken = 1'b0;
        wait_req("wait_br_redir");
        chk("wait_br_addr", ifc.imem_addr, 32'h0000_1000);
        chk("wait_br_nodeliv", 32'(del_pc.size()), 32'(n0));
        wait_valid("wait_br_valid");
        chk("wait_br_pc", ifc.if_pc, 32'h0000_1000);
        kmin = 1;
        kmax = 1;

        // Redirect during HOLD with downstream stalled
        ifc.if_ready = 1'b0;
        wait_valid("hold_br_valid");
        ifc.br_taken  = 1'b1;
        ifc.br_target = 32'h0000_0040;
        @(negedge clk);
        ifc.br_taken = 1'b0;
        chk("hold_br_valid0", 32'(ifc.if_valid), 32'd0);
        chk("hold_br_req", 32'(ifc.imem_req), 32'd1);
        chk("hold_br_addr", ifc.imem_addr, 32'h0000_0040);

        // Redirect in the same cycle as the grant at 0x20
        wait_valid("gnt_br_valid");
        ifc.br_taken  = 1'b1;
        ifc.br_target = 32'h0000_0020;
        @(negedge clk);
        chk("gnt_br_addr20", ifc.imem_addr, 32'h0000_0020);
        ifc.br_target = 32'h0000_0080;
        ifc.if_ready  = 1'b1;
        @(negedge clk);
        ifc.br_taken = 1'b0;
        wait_req("gnt_br_req");
        chk("gnt_br_addr80", ifc.imem_addr, 32'h0000_0080);
        wait_valid("gnt_br_v80");
        chk("gnt_br_pc80", ifc.if_pc, 32'h0000_0080);

        // Randomized traffic
        gnt_pct = 70;
        kmax    = 4;
        spur_en = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            ifc.br_taken  = ($urandom_range(9) == 0);
            ifc.br_target = $urandom;
            ifc.if_ready  = ($urandom_range(2) != 0);
        end
        ifc.br_taken = 1'b0;
        ifc.if_ready = 1'b1;
        spur_en      = 1'b0;
        gnt_pct      = 100;

        // Reset during WAIT; the stale response must be ignored
        kmin = 3;
        kmax = 3;
        wait_req("rst_wait_req");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_req", 32'(ifc.imem_req), 32'd0);
        chk("arst_addr", ifc.imem_addr, 32'h0);
        chk("arst_valid", 32'(ifc.if_valid), 32'd0);
        chk("arst_pc", ifc.if_pc, 32'h0);
        chk("arst_instr", ifc.if_instr, NOP);
        gnt_pct = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("stale_valid", 32'(ifc.if_valid), 32'd0);
        n0 = del_pc.size();
        kmin    = 1;
        kmax    = 1;
        gnt_pct = 100;
        wait_deliv(n0 + 1);
        if (del_pc.size() > n0) chk("post_rst_pc", del_pc[n0], 32'h0);

        // High reset PC wraps to 0 on the second fetch
        chk("wrap_count", 32'(n2), 32'd2);
        chk("wrap_addr0", addr2[0], 32'hFFFF_FFFC);
        chk("wrap_addr1", addr2[1], 32'h0000_0000);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
